rnd_symbol_collector: RTL and testbench

//  Downstream consumer of the RND LFSR datapath's 2-bit x_out symbol stream.

---
 rtl/rnd_pkg.sv | 12 +
 rtl/rnd_collect_counter.sv | 26 ++
 rtl/rnd_symbol_collector.sv | 105 ++++++++++
 tb/tb_rnd_symbol_collector.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rnd_pkg.sv
// Shared constants and state encoding for the RND symbol collector.
package rnd_pkg;

    localparam int SYM_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/rnd_collect_counter.sv
// Symbol counter with sync init/enable; co flags the TERMINAL count and
// the next enabled step wraps back to zero.
module rnd_collect_counter #(
    parameter int               WIDTH    = 2,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic en,
    output logic co
);

    logic [WIDTH-1:0] count;

    assign co = (count == TERMINAL);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            count <= '0;
        end else if (en) begin
            count <= co ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rnd_symbol_collector.sv
// Packs NSYM 2-bit RND symbols into a word behind a valid/ready handoff.
// Optional even-parity output under macro RND_COLLECT_PARITY_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  ST_IDLE | no symbols held, ready for the first symbol
//  ST_FILL | partial word, 0 < count < NSYM
//  ST_FULL | word complete, waiting on out_ready
module rnd_symbol_collector
    import rnd_pkg::*;
#(
    parameter int NSYM      = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  sym_valid,
    input  logic [SYM_W-1:0]      sym,
    output logic                  sym_ready,
    output logic                  word_valid,
    output logic [SYM_W*NSYM-1:0] word,
    input  logic                  out_ready
`ifdef RND_COLLECT_PARITY_EN
    ,
    output logic                  word_par
`endif
);

    localparam int WORD_W = SYM_W * NSYM;

    state_t              state;
    logic                ready_q;
    logic                accept;
    logic                last_sym;
    logic [WORD_W-1:0]   next_word;

    // Reset holds the generator off for the whole reset cycle.
    assign sym_ready = ready_q & ~rst;
    assign accept    = sym_valid & sym_ready;
    assign next_word = {word[WORD_W-SYM_W-1:0], sym};

    rnd_collect_counter #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL (CNT_WIDTH'(NSYM - 1))
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .init (clr),
        .en   (accept),
        .co   (last_sym)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= ST_IDLE;
            word       <= '0;
            word_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        word  <= next_word;
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        word <= next_word;
                        if (last_sym) begin
                            state      <= ST_FULL;
                            word_valid <= 1'b1;
                            ready_q    <= 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state      <= ST_IDLE;
                        word_valid <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    word_valid <= 1'b0;
                    ready_q    <= 1'b1;
                end
            endcase
        end
    end

`ifdef RND_COLLECT_PARITY_EN
    // Tracks word exactly: only accepts change word outside reset/clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_par <= 1'b0;
        end else if (accept) begin
            word_par <= ^next_word;
        end
    end
`endif

endmodule

// File: tb/tb_rnd_symbol_collector.sv
// Randomized self-checking bench for rnd_symbol_collector (NSYM=4) against
// a queue-based reference of accepted symbols and handed-off words.
module tb_rnd_symbol_collector;

    localparam int NSYM = 4;

    logic       clk = 1'b0;
    logic       rst, clr, sym_valid, out_ready;
    logic [1:0] sym;
    logic       sym_ready, word_valid;
    logic [7:0] word;
`ifdef RND_COLLECT_PARITY_EN
    logic       word_par;
`endif

    always #5 clk = ~clk;

    rnd_symbol_collector #(
        .NSYM      (NSYM),
        .CNT_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .sym_ready  (sym_ready),
        .word_valid (word_valid),
        .word       (word),
        .out_ready  (out_ready)
`ifdef RND_COLLECT_PARITY_EN
        ,
        .word_par   (word_par)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: symbols accepted since the last reset/clr (newest last),
    // symbols in the current word, and the stream awaiting handoff.
    int  m_hist[$];
    int  sbq[$];
    int  m_cnt   = 0;
    bit  m_valid = 1'b0;
    bit  m_ready = 1'b1;
    int  words   = 0;

    function automatic logic [7:0] m_word();
        logic [7:0] w = 8'h00;
        foreach (m_hist[i]) w = {w[5:0], 2'(m_hist[i])};
        return w;
    endfunction

    task automatic cycle(input bit r, input bit c, input bit v, input logic [1:0] s, input bit o);
        logic [7:0] exp_w;
        rst = r; clr = c; sym_valid = v; sym = s; out_ready = o;
        if (!r && !c && m_valid && o) begin
            exp_w = 8'h00;
            for (int k = 0; k < NSYM; k++) exp_w = {exp_w[5:0], 2'(sbq.pop_front())};
            check_val("handoff_word", 32'(word), 32'(exp_w));
            words++;
        end
        if (r || c) begin
            m_hist.delete(); sbq.delete();
            m_cnt = 0; m_valid = 1'b0; m_ready = 1'b1;
        end else if (m_valid) begin
            if (o) begin m_valid = 1'b0; m_ready = 1'b1; end
        end else if (v) begin
            m_hist.push_back(int'(s));
            if (m_hist.size() > NSYM) void'(m_hist.pop_front());
            sbq.push_back(int'(s));
            m_cnt++;
            if (m_cnt == NSYM) begin m_cnt = 0; m_valid = 1'b1; m_ready = 1'b0; end
        end
        @(negedge clk);
        check_val("word_valid", 32'(word_valid), 32'(m_valid));
        check_val("sym_ready", 32'(sym_ready), 32'(m_ready && !r));
        check_val("word", 32'(word), 32'(m_word()));
`ifdef RND_COLLECT_PARITY_EN
        check_val("word_par", 32'(word_par), 32'(^m_word()));
`endif
    endtask

    logic [15:0] lfsr;
    bit          v_r, o_r, acc;
    int          budget;

    task automatic lfsr_step();
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    endtask

    initial begin
        // reset
        cycle(1, 0, 0, 2'd0, 0);
        cycle(1, 0, 0, 2'd0, 0);
        cycle(0, 0, 0, 2'd0, 0);
        check_val("rst_word", 32'(word), 32'h0);
        check_val("rst_word_valid", 32'(word_valid), 32'h0);
        check_val("rst_sym_ready", 32'(sym_ready), 32'h1);

        // fill 3,0,2,1
        cycle(0, 0, 1, 2'd3, 0);
        cycle(0, 0, 1, 2'd0, 0);
        cycle(0, 0, 1, 2'd2, 0);
        cycle(0, 0, 1, 2'd1, 0);
        check_val("fill_word", 32'(word), 32'hC9);
        check_val("fill_valid", 32'(word_valid), 32'h1);
        check_val("fill_ready", 32'(sym_ready), 32'h0);
`ifdef RND_COLLECT_PARITY_EN
        check_val("fill_par", 32'(word_par), 32'h0);
`endif

        // stall with symbols offered
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 2'($urandom_range(0, 3)), 0);
        check_val("stall_word", 32'(word), 32'hC9);
        check_val("stall_no_accept", 32'(sbq.size()), 32'd4);
        cycle(0, 0, 0, 2'd0, 1);
        check_val("release_valid", 32'(word_valid), 32'h0);
        check_val("release_ready", 32'(sym_ready), 32'h1);

        // abort then 1,1,1,1
        cycle(0, 0, 1, 2'd2, 0);
        cycle(0, 0, 1, 2'd2, 0);
        cycle(0, 1, 1, 2'd3, 0);
        check_val("clr_word", 32'(word), 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 2'd1, 0);
        check_val("after_clr_word", 32'(word), 32'h55);
        check_val("after_clr_valid", 32'(word_valid), 32'h1);
`ifdef RND_COLLECT_PARITY_EN
        check_val("after_clr_par", 32'(word_par), 32'h0);
`endif

        // reset while FULL
        cycle(0, 0, 0, 2'd0, 1);
        cycle(0, 0, 1, 2'd3, 0);
        cycle(0, 0, 1, 2'd0, 0);
        cycle(0, 0, 1, 2'd2, 0);
        cycle(0, 0, 1, 2'd1, 0);
        check_val("pre_rst_word", 32'(word), 32'hC9);
        cycle(1, 0, 1, 2'd2, 1);
        check_val("mid_rst_word", 32'(word), 32'h0);
        check_val("mid_rst_valid", 32'(word_valid), 32'h0);
        cycle(0, 0, 0, 2'd0, 0);
        check_val("mid_rst_ready", 32'(sym_ready), 32'h1);

        // random LFSR stream, random back-pressure
        lfsr   = 16'hACE1;
        words  = 0;
        budget = 40000;
        while (words < 1000 && budget > 0) begin
            v_r = ($urandom_range(0, 3) != 0);
            o_r = ($urandom_range(0, 1) != 0);
            acc = v_r && m_ready && !m_valid;
            cycle(0, 0, v_r, lfsr[1:0], o_r);
            if (acc) begin lfsr_step(); lfsr_step(); end
            budget--;
        end
        check_val("rnd_words", 32'(words), 32'd1000);
        check_val("rnd_pending_syms", 32'(sbq.size()), 32'(m_cnt + (m_valid ? NSYM : 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
